// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter on the read side of the TX FIFO: pops one byte at a time and serialises it on o_tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_tx_fifo_drain #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_fifo_empty,
    input  logic [NB_DATA-1:0] i_fifo_data,
    output logic               o_fifo_rd,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);
    localparam int TC_MAX = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int TC_W   = $clog2(TC_MAX);
    localparam int BC_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam logic [TC_W-1:0] TC_BIT_END  = TC_W'(15);
    localparam logic [TC_W-1:0] TC_STOP_END = TC_W'(SB_TICK - 1);
    localparam logic [BC_W-1:0] BC_LAST     = BC_W'(NB_DATA - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state, state_n;
    logic [TC_W-1:0]    tc, tc_n;
    logic [BC_W-1:0]    bc, bc_n;
    logic [NB_DATA-1:0] shift, shift_n, shift_nx;
    logic               tx, tx_n;
    logic               done, done_n;
    logic               fifo_rd;
`ifdef UART_TX_PARITY_EN
    logic               par, par_n;
`endif

    assign shift_nx = shift >> 1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            tc    <= '0;
            bc    <= '0;
            shift <= '0;
            tx    <= 1'b1;
            done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tc    <= tc_n;
            bc    <= bc_n;
            shift <= shift_n;
            tx    <= tx_n;
            done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // The line level is computed one cycle ahead so o_tx always comes straight from a flop.
    always_comb begin
        state_n = state;
        tc_n    = tc;
        bc_n    = bc;
        shift_n = shift;
        tx_n    = tx;
        done_n  = 1'b0;
        fifo_rd = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!i_fifo_empty && !i_reset) begin
                    fifo_rd = 1'b1;
                    shift_n = i_fifo_data;
                    tc_n    = '0;
                    tx_n    = 1'b0;
                    state_n = START;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^i_fifo_data;
`endif
                end
            end
            START: begin
                if (i_tick) begin
                    if (tc == TC_BIT_END) begin
                        tc_n    = '0;
                        bc_n    = '0;
                        tx_n    = shift[0];
                        state_n = DATA;
                    end else begin
                        tc_n = tc + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tc == TC_BIT_END) begin
                        tc_n    = '0;
                        shift_n = shift_nx;
                        if (bc == BC_LAST) begin
`ifdef UART_TX_PARITY_EN
                            tx_n    = par;
                            state_n = PARITY;
`else
                            tx_n    = 1'b1;
                            state_n = STOP;
`endif
                        end else begin
                            bc_n = bc + 1'b1;
                            tx_n = shift_nx[0];
                        end
                    end else begin
                        tc_n = tc + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (tc == TC_BIT_END) begin
                        tc_n    = '0;
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        tc_n = tc + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (i_tick) begin
                    if (tc == TC_STOP_END) begin
                        tc_n    = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tc_n = tc + 1'b1;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    assign o_fifo_rd = fifo_rd;
    assign o_tx      = tx;
    assign o_tx_busy = (state != IDLE);
    assign o_tx_done = done;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain: a tick-counting frame model plus a FIFO queue predict every cycle.
// Build with UART_TX_PARITY_EN defined to exercise the parity build; the model follows the same macro.
module tb_uart_tx_fifo_drain;
    localparam int NB_DATA = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME_TICKS = 16 * (1 + NB_DATA + P) + SB_TICK;

    logic               clk = 1'b0;
    logic               reset;
    logic               tick;
    logic               fifo_empty;
    logic [NB_DATA-1:0] fifo_data;
    logic               fifo_rd;
    logic               tx;
    logic               tx_busy;
    logic               tx_done;

    int checks   = 0;
    int failures = 0;

    logic [NB_DATA-1:0] fifo_q[$];
    int                 pop_cycles[$];
    int                 done_cycles[$];
    logic               busy_log[$];

    always #5 clk = ~clk;

    uart_tx_fifo_drain #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_tick      (tick),
        .i_fifo_empty(fifo_empty),
        .i_fifo_data (fifo_data),
        .o_fifo_rd   (fifo_rd),
        .o_tx        (tx),
        .o_tx_busy   (tx_busy),
        .o_tx_done   (tx_done)
    );

    // Line level t ticks into a frame: start, data LSB-first, optional even parity, stop.
    function automatic logic exp_line(input logic [NB_DATA-1:0] b, input int t);
        int seg;
        seg = t / 16;
        if (t >= FRAME_TICKS) return 1'b1;
        if (seg == 0) return 1'b0;
        if (seg <= NB_DATA) return b[seg-1];
        if (P == 1 && seg == NB_DATA + 1) return ^b;
        return 1'b1;
    endfunction

    function automatic int count_busy();
        int n;
        n = 0;
        foreach (busy_log[i]) if (busy_log[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        tick       = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // div>0: tick on every div-th cycle aligned to cycle 0; div==0: random ticks.
    task automatic run_stream(input int div, input int max_cycles, input int rst_at, input string name);
        bit                 in_frame;
        bit                 done_exp;
        int                 t;
        logic [NB_DATA-1:0] cur;
        logic               e_rd, e_tx, e_busy, e_done;
        in_frame = 0;
        done_exp = 0;
        t        = 0;
        cur      = '0;
        pop_cycles.delete();
        done_cycles.delete();
        busy_log.delete();
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            reset      = (cyc == rst_at);
            fifo_empty = (fifo_q.size() == 0);
            fifo_data  = fifo_empty ? NB_DATA'($urandom) : fifo_q[0];
            tick       = (div > 0) ? ((cyc % div) == 0) : ($urandom_range(0, 1) == 0);
            e_rd   = !in_frame && !fifo_empty && !reset;
            e_tx   = in_frame ? exp_line(cur, t) : 1'b1;
            e_busy = in_frame;
            e_done = done_exp;
            @(negedge clk);
            checks++;
            if (fifo_rd !== e_rd) begin
                failures++;
                $display("[TB] FAIL %s_rd cycle %0d: got %b expected %b", name, cyc, fifo_rd, e_rd);
            end
            checks++;
            if (tx !== e_tx) begin
                failures++;
                $display("[TB] FAIL %s_tx cycle %0d: got %b expected %b", name, cyc, tx, e_tx);
            end
            checks++;
            if (tx_busy !== e_busy) begin
                failures++;
                $display("[TB] FAIL %s_busy cycle %0d: got %b expected %b", name, cyc, tx_busy, e_busy);
            end
            checks++;
            if (tx_done !== e_done) begin
                failures++;
                $display("[TB] FAIL %s_done cycle %0d: got %b expected %b", name, cyc, tx_done, e_done);
            end
            if (fifo_rd === 1'b1) pop_cycles.push_back(cyc);
            if (tx_done === 1'b1) done_cycles.push_back(cyc);
            busy_log.push_back(tx_busy);
            @(posedge clk); #1;
            if (reset) begin
                in_frame = 0;
                done_exp = 0;
                t        = 0;
            end else if (!in_frame) begin
                done_exp = 0;
                if (!fifo_empty) begin
                    cur      = fifo_q.pop_front();
                    in_frame = 1;
                    t        = 0;
                end
            end else begin
                done_exp = 0;
                if (tick) t++;
                if (t == FRAME_TICKS) begin
                    in_frame = 0;
                    done_exp = 1;
                end
            end
        end
        reset = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 8'h5A;
        tick       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd: got %b expected 0", fifo_rd); end
            checks++;
            if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
            checks++;
            if (tx_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy); end
            checks++;
            if (tx_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done); end
            @(posedge clk); #1;
        end
        fifo_q.delete();
        run_stream(1, 6, -1, "post_reset");
        checks++;
        if (pop_cycles.size() != 0) begin
            failures++;
            $display("[TB] FAIL post_reset_pops: got %0d expected 0", pop_cycles.size());
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        fifo_q = '{8'hA5};
        run_stream(1, FRAME_TICKS + 10, -1, "single");
        checks++;
        if (pop_cycles.size() != 1) begin
            failures++;
            $display("[TB] FAIL single_pops: got %0d expected 1", pop_cycles.size());
        end
        checks++;
        if (count_busy() != FRAME_TICKS) begin
            failures++;
            $display("[TB] FAIL single_busy_len: got %0d expected %0d", count_busy(), FRAME_TICKS);
        end
        // Pop in cycle 0, busy cycles 1..FRAME_TICKS, done in the following cycle.
        checks++;
        if (done_cycles.size() != 1 || pop_cycles.size() != 1 ||
            done_cycles[0] - pop_cycles[0] != FRAME_TICKS + 1) begin
            failures++;
            $display("[TB] FAIL single_done_time: got %0d dones, first at %0d expected 1 at %0d",
                     done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1, FRAME_TICKS + 1);
        end
    endtask

    task automatic test_back_to_back();
        int idle_cycles;
        do_reset();
        fifo_q = '{8'h00, 8'hFF};
        run_stream(1, 2 * FRAME_TICKS + 10, -1, "b2b");
        checks++;
        if (pop_cycles.size() != 2) begin
            failures++;
            $display("[TB] FAIL b2b_pops: got %0d expected 2", pop_cycles.size());
        end else begin
            checks++;
            if (pop_cycles[1] - pop_cycles[0] != FRAME_TICKS + 1) begin
                failures++;
                $display("[TB] FAIL b2b_pop_gap: got %0d expected %0d", pop_cycles[1] - pop_cycles[0], FRAME_TICKS + 1);
            end
            checks++;
            if (done_cycles.size() < 1 || done_cycles[0] != pop_cycles[1]) begin
                failures++;
                $display("[TB] FAIL b2b_done_with_pop: got done at %0d expected %0d",
                         (done_cycles.size() > 0) ? done_cycles[0] : -1, pop_cycles[1]);
            end
            idle_cycles = 0;
            for (int c = pop_cycles[0] + 1; c <= pop_cycles[1]; c++)
                if (busy_log[c] === 1'b0) idle_cycles++;
            checks++;
            if (idle_cycles != 1) begin
                failures++;
                $display("[TB] FAIL b2b_idle_gap: got %0d expected 1", idle_cycles);
            end
        end
    endtask

    task automatic test_slow_tick();
        do_reset();
        fifo_q = '{8'h3C};
        run_stream(4, 4 * FRAME_TICKS + 10, -1, "slow");
        checks++;
        if (count_busy() != 4 * FRAME_TICKS) begin
            failures++;
            $display("[TB] FAIL slow_busy_len: got %0d expected %0d", count_busy(), 4 * FRAME_TICKS);
        end
        checks++;
        if (done_cycles.size() != 1) begin
            failures++;
            $display("[TB] FAIL slow_dones: got %0d expected 1", done_cycles.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        fifo_q = '{8'hF0};
        // Data bit 2 occupies cycles 49..64 at one tick per cycle; reset lands in the middle.
        run_stream(1, 120, 56, "midrst");
        checks++;
        if (done_cycles.size() != 0) begin
            failures++;
            $display("[TB] FAIL midrst_dones: got %0d expected 0", done_cycles.size());
        end
        checks++;
        if (pop_cycles.size() != 1) begin
            failures++;
            $display("[TB] FAIL midrst_pops: got %0d expected 1", pop_cycles.size());
        end
        checks++;
        if (count_busy() != 56) begin
            failures++;
            $display("[TB] FAIL midrst_busy_len: got %0d expected 56", count_busy());
        end
    endtask

    task automatic test_parity_bytes();
        do_reset();
        fifo_q = '{8'h07, 8'h03};
        run_stream(1, 2 * FRAME_TICKS + 10, -1, "parity");
        checks++;
        if (count_busy() != 2 * FRAME_TICKS) begin
            failures++;
            $display("[TB] FAIL parity_busy_len: got %0d expected %0d", count_busy(), 2 * FRAME_TICKS);
        end
        checks++;
        if (done_cycles.size() != 2) begin
            failures++;
            $display("[TB] FAIL parity_dones: got %0d expected 2", done_cycles.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        fifo_q.delete();
        for (int i = 0; i < 6; i++) fifo_q.push_back(NB_DATA'($urandom));
        run_stream(0, 3200, -1, "random");
        checks++;
        if (done_cycles.size() != 6) begin
            failures++;
            $display("[TB] FAIL random_dones: got %0d expected 6", done_cycles.size());
        end
        checks++;
        if (pop_cycles.size() != 6) begin
            failures++;
            $display("[TB] FAIL random_pops: got %0d expected 6", pop_cycles.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_slow_tick();
        test_reset_mid_frame();
        test_parity_bytes();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
